// File: rtl/tour_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tour_pkg                                                          |
// | Shared types and constants for the knight's-tour command sequencer and     |
// | the tour solver: FSM state enum, command opcodes, robot headings, response |
// | bytes and the one-hot move bit assignment.                                 |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } tour_cmd_state_t;

  localparam logic [3:0] OP_MOVE         = 4'h4;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h5;

  // Robot headings: north is the zero reference.
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_IDLE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  // Index of the final move of a 24-move tour.
  localparam logic [4:0] LAST_INDX = 5'd23;

  // Move bit positions, named by (dx,dy); +x east, +y north.
  localparam int MV_P1_P2 = 0;  // (+1,+2)
  localparam int MV_M1_P2 = 1;  // (-1,+2)
  localparam int MV_M2_P1 = 2;  // (-2,+1)
  localparam int MV_M2_M1 = 3;  // (-2,-1)
  localparam int MV_M1_M2 = 4;  // (-1,-2)
  localparam int MV_P1_M2 = 5;  // (+1,-2)
  localparam int MV_P2_M1 = 6;  // (+2,-1)
  localparam int MV_P2_P1 = 7;  // (+2,+1)

  function automatic logic [15:0] pack_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tour_move_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tour_move_decode                                                  |
// | Converts a one-hot knight move into a vertical leg and a horizontal leg,   |
// | each as a heading plus a square count. Any non-one-hot input decodes to    |
// | heading north with zero squares on both legs.                              |
// | Ports   : move         in  8  one-hot move                                  |
// |           vert_heading out 8  heading of the vertical leg                   |
// |           vert_squares out 4  length of the vertical leg                    |
// |           horz_heading out 8  heading of the horizontal leg                 |
// |           horz_squares out 4  length of the horizontal leg                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] vert_heading,
  output logic [3:0] vert_squares,
  output logic [7:0] horz_heading,
  output logic [3:0] horz_squares
);

  always_comb begin
    vert_heading = HDG_N;
    vert_squares = 4'd0;
    horz_heading = HDG_N;
    horz_squares = 4'd0;
    case (move)
      (8'd1 << MV_P1_P2): begin
        vert_heading = HDG_N; vert_squares = 4'd2;
        horz_heading = HDG_E; horz_squares = 4'd1;
      end
      (8'd1 << MV_M1_P2): begin
        vert_heading = HDG_N; vert_squares = 4'd2;
        horz_heading = HDG_W; horz_squares = 4'd1;
      end
      (8'd1 << MV_M2_P1): begin
        vert_heading = HDG_N; vert_squares = 4'd1;
        horz_heading = HDG_W; horz_squares = 4'd2;
      end
      (8'd1 << MV_M2_M1): begin
        vert_heading = HDG_S; vert_squares = 4'd1;
        horz_heading = HDG_W; horz_squares = 4'd2;
      end
      (8'd1 << MV_M1_M2): begin
        vert_heading = HDG_S; vert_squares = 4'd2;
        horz_heading = HDG_W; horz_squares = 4'd1;
      end
      (8'd1 << MV_P1_M2): begin
        vert_heading = HDG_S; vert_squares = 4'd2;
        horz_heading = HDG_E; horz_squares = 4'd1;
      end
      (8'd1 << MV_P2_M1): begin
        vert_heading = HDG_S; vert_squares = 4'd1;
        horz_heading = HDG_E; horz_squares = 4'd2;
      end
      (8'd1 << MV_P2_P1): begin
        vert_heading = HDG_N; vert_squares = 4'd1;
        horz_heading = HDG_E; horz_squares = 4'd2;
      end
      default: begin
        // Illegal (non-one-hot) move: keep the north/zero defaults.
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tour_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tour_cmd_seq                                                      |
// | Replays a solved knight's tour as robot commands: each move becomes a      |
// | vertical command followed by a horizontal command. Each command is held    |
// | until the command processor clears it and reports completion. In IDLE the  |
// | UART command path passes straight through.                                 |
// | Ports   : clk, rst_n (async, active-low)                                    |
// |           start_tour   in  1   begin replay (IDLE only)                     |
// |           move         in  8   one-hot move at mv_indx (zero-latency read)  |
// |           mv_indx      out 5   index of move being replayed                 |
// |           cmd_UART     in  16  UART command                                 |
// |           cmd_rdy_UART in  1   UART command valid                           |
// |           cmd          out 16  {opcode, heading, squares}                   |
// |           cmd_rdy      out 1   cmd valid                                    |
// |           clr_cmd_rdy  in  1   command processor took cmd                   |
// |           send_resp    in  1   command processor finished cmd               |
// |           resp         out 8   response byte to UART                        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter logic FANFARE_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  tour_cmd_state_t state, state_nxt;
  logic [4:0]      indx_nxt;

  logic [7:0]  vert_heading, horz_heading;
  logic [3:0]  vert_squares, horz_squares;
  logic        at_last;
  logic [3:0]  horz_op;
  logic [15:0] vert_cmd, horz_cmd;

  tour_move_decode u_decode (
    .move         (move),
    .vert_heading (vert_heading),
    .vert_squares (vert_squares),
    .horz_heading (horz_heading),
    .horz_squares (horz_squares)
  );

  assign at_last  = (mv_indx == LAST_INDX);
  assign horz_op  = (FANFARE_LAST && at_last) ? OP_MOVE_FANFARE : OP_MOVE;
  assign vert_cmd = pack_cmd(OP_MOVE, vert_heading, vert_squares);
  assign horz_cmd = pack_cmd(horz_op, horz_heading, horz_squares);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      state   <= state_nxt;
      mv_indx <= indx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    indx_nxt  = mv_indx;
    cmd       = cmd_UART;
    cmd_rdy   = 1'b0;
    resp      = RESP_BUSY;
    case (state)
      IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_IDLE;
        if (start_tour) begin
          indx_nxt  = 5'd0;
          state_nxt = VERT;
        end
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        // send_resp here is deliberately ignored: completion only counts
        // once the command has been taken.
        if (clr_cmd_rdy) state_nxt = WAIT_V;
      end
      WAIT_V: begin
        cmd = vert_cmd;
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        // Signal end-of-tour to the UART while the final leg completes.
        if (at_last) resp = RESP_IDLE;
        if (send_resp) begin
          if (at_last) begin
            state_nxt = IDLE;
          end else begin
            indx_nxt  = mv_indx + 5'd1;
            state_nxt = VERT;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tour_cmd_seq                                                   |
// | Scoreboard bench for tour_cmd_seq. A driver plays the command processor    |
// | and the solver's move memory; a monitor pops expected commands whenever    |
// | cmd_rdy rises and compares cmd, mv_indx and resp.                          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tour_cmd_seq;

  typedef struct {
    logic [15:0] cmd;
    logic [4:0]  idx;
    logic [7:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;

  logic [7:0] tour_mem [24];
  exp_t       exp_q [$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         DX [8] = '{ 1, -1, -2, -2, -1,  1,  2,  2};
  int         DY [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

  // Solver read port: zero-latency lookup.
  assign move = tour_mem[mv_indx];

  tour_cmd_seq #(.FANFARE_LAST(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a move is a (dx,dy) displacement; vertical leg first.
  function automatic logic [15:0] model_cmd(input logic [7:0] mv, input int idx, input bit horiz);
    logic [3:0] op;
    int d, k;
    op = (horiz && idx == 23) ? 4'h5 : 4'h4;
    if ($countones(mv) != 1) return {op, 8'h00, 4'h0};
    k = 0;
    for (int b = 0; b < 8; b++) if (mv[b]) k = b;
    d = horiz ? DX[k] : DY[k];
    if (horiz) return {op, (d > 0) ? 8'hBF : 8'h3F, 4'((d > 0) ? d : -d)};
    else       return {op, (d > 0) ? 8'h00 : 8'h7F, 4'((d > 0) ? d : -d)};
  endfunction

  // Monitor: each rising cmd_rdy is one presented command.
  initial begin
    logic prev_rdy;
    exp_t e;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_cmd: got cmd %h idx %0d, expected no command", cmd, mv_indx);
        end else begin
          e = exp_q.pop_front();
          check("sb_cmd", {16'h0, cmd}, {16'h0, e.cmd});
          check("sb_mv_indx", {27'h0, mv_indx}, {27'h0, e.idx});
          check("sb_resp", {24'h0, resp}, {24'h0, e.resp});
        end
      end
      prev_rdy = cmd_rdy;
    end
  end

  task automatic uart_pass(input logic [15:0] val, input logic [4:0] idx);
    exp_q.push_back('{cmd: val, idx: idx, resp: 8'hA5});
    @(posedge clk); #1;
    cmd_UART = val;
    cmd_rdy_UART = 1'b1;
    repeat (2) @(posedge clk);
    #1 cmd_rdy_UART = 1'b0;
    @(negedge clk);
    check("uart_rdy_drop", {31'h0, cmd_rdy}, 32'h0);
  endtask

  // Serve one command as the command processor. Returns 0 on timeout.
  task automatic serve(input int idx, input bit horiz, input bit abort, output bit ok);
    int t;
    ok = 1'b0;
    for (t = 0; t < 20; t++) begin
      if (cmd_rdy === 1'b1) break;
      @(negedge clk);
    end
    if (t == 20) begin
      check("cmd_rdy_timeout", {31'h0, cmd_rdy}, 32'h1);
      return;
    end
    cmd_UART = 16'($urandom);
    if (!horiz && idx == 3) begin
      // Completion before the command is taken must be ignored.
      @(posedge clk); #1 send_resp = 1'b1;
      @(posedge clk); #1 send_resp = 1'b0;
      @(negedge clk);
      check("early_resp_rdy", {31'h0, cmd_rdy}, 32'h1);
      check("early_resp_idx", {27'h0, mv_indx}, idx);
      check("early_resp_cmd", {16'h0, cmd}, {16'h0, model_cmd(tour_mem[idx], idx, 1'b0)});
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b1;
    send_resp   = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    if (!horiz && idx == 2) cmd_rdy_UART = 1'b1;
    @(negedge clk);
    check("clr_drops_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("wait_resp", {24'h0, resp}, (horiz && idx == 23) ? 32'hA5 : 32'h5A);
    cmd_rdy_UART = 1'b0;
    if (!horiz && idx == 7) begin
      @(posedge clk); #1 start_tour = 1'b1;
      @(posedge clk); #1 start_tour = 1'b0;
    end
    if (abort) begin
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("abort_idx", {27'h0, mv_indx}, 32'h0);
      check("abort_rdy", {31'h0, cmd_rdy}, 32'h0);
      check("abort_resp", {24'h0, resp}, 32'hA5);
      @(posedge clk); #1 rst_n = 1'b1;
      ok = 1'b1;
      return;
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1 send_resp = 1'b1;
    @(posedge clk); #1 send_resp = 1'b0;
    @(negedge clk);
    if (horiz && idx == 23) begin
      check("end_idle_resp", {24'h0, resp}, 32'hA5);
      check("end_hold_idx", {27'h0, mv_indx}, 32'd23);
    end else begin
      check("next_cmd_latency", {31'h0, cmd_rdy}, 32'h1);
    end
    ok = 1'b1;
  endtask

  task automatic run_tour(input int abort_at);
    int last;
    bit ok;
    last = (abort_at >= 0) ? abort_at : 23;
    for (int i = 0; i <= last; i++) begin
      exp_q.push_back('{cmd: model_cmd(tour_mem[i], i, 1'b0), idx: 5'(i), resp: 8'h5A});
      exp_q.push_back('{cmd: model_cmd(tour_mem[i], i, 1'b1), idx: 5'(i), resp: 8'h5A});
    end
    @(posedge clk); #1 start_tour = 1'b1;
    @(posedge clk); #1 start_tour = 1'b0;
    @(negedge clk);
    check("start_latency_rdy", {31'h0, cmd_rdy}, 32'h1);
    check("start_idx", {27'h0, mv_indx}, 32'h0);
    for (int i = 0; i <= last; i++) begin
      serve(i, 1'b0, 1'b0, ok);
      if (!ok) return;
      serve(i, 1'b1, (i == abort_at), ok);
      if (!ok) return;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 24; i++) tour_mem[i] = 8'd1 << $urandom_range(0, 7);
    tour_mem[0]  = 8'h01;
    tour_mem[1]  = 8'h08;
    tour_mem[5]  = 8'h00;
    tour_mem[12] = 8'h81;

    repeat (3) @(posedge clk);
    #1;
    check("reset_idx", {27'h0, mv_indx}, 32'h0);
    check("reset_resp", {24'h0, resp}, 32'hA5);
    check("reset_rdy", {31'h0, cmd_rdy}, 32'h0);
    rst_n = 1'b1;

    uart_pass(16'h1234, 5'd0);
    run_tour(-1);
    uart_pass(16'($urandom), 5'd23);

    for (int i = 0; i < 24; i++) tour_mem[i] = 8'd1 << $urandom_range(0, 7);
    run_tour(10);
    uart_pass(16'($urandom), 5'd0);

    for (int i = 0; i < 24; i++) tour_mem[i] = 8'd1 << $urandom_range(0, 7);
    run_tour(-1);
    uart_pass(16'hBEEF, 5'd23);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
